// File: rtl/fp_vec_mul_seq.sv
// Vector front-end for a combinational FP multiplier: captures a packed operand
// pair, feeds one lane pair per cycle to an external fp_mul, gathers the products
// and presents the result vector with a valid/ready handshake plus ORed lane flags.
module fp_vec_mul_seq #(
    parameter int E_WIDTH = 8,
    parameter int M_WIDTH = 23,
    parameter int I_WIDTH = E_WIDTH + M_WIDTH + 1,
    parameter int LANES   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*I_WIDTH-1:0] vec_a,
    input  logic [LANES*I_WIDTH-1:0] vec_b,
    output logic [I_WIDTH-1:0]       mul_a,
    output logic [I_WIDTH-1:0]       mul_b,
    input  logic [I_WIDTH-1:0]       mul_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*I_WIDTH-1:0] vec_out,
    output logic                     flag_nan,
    output logic                     flag_inf,
    output logic                     flag_zero,
    output logic                     busy
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [LANES*I_WIDTH-1:0] a_q, a_d;
    logic [LANES*I_WIDTH-1:0] b_q, b_d;
    logic [LANES*I_WIDTH-1:0] res_q, res_d;
    logic                     nan_q, nan_d;
    logic                     inf_q, inf_d;
    logic                     zero_q, zero_d;

    logic [E_WIDTH-1:0]       prod_exp;
    logic [M_WIDTH-1:0]       prod_man;
    logic                     prod_nan, prod_inf, prod_zero;

    // Classify the product currently returned by the multiplier.
    always_comb begin
        prod_exp  = mul_out[I_WIDTH-2 -: E_WIDTH];
        prod_man  = mul_out[M_WIDTH-1:0];
        prod_nan  = (prod_exp == '1) && (prod_man != '0);
        prod_inf  = (prod_exp == '1) && (prod_man == '0);
        prod_zero = (prod_exp == '0) && (prod_man == '0);
    end

    // Next-state, datapath updates and multiplier operand mux.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        nan_d   = nan_q;
        inf_d   = inf_q;
        zero_d  = zero_q;
        mul_a   = '0;
        mul_b   = '0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = vec_a;
                    b_d     = vec_b;
                    res_d   = '0;
                    nan_d   = 1'b0;
                    inf_d   = 1'b0;
                    zero_d  = 1'b0;
                    idx_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mul_a = a_q[int'(idx_q)*I_WIDTH +: I_WIDTH];
                mul_b = b_q[int'(idx_q)*I_WIDTH +: I_WIDTH];
                res_d[int'(idx_q)*I_WIDTH +: I_WIDTH] = mul_out;
                nan_d  = nan_q  | prod_nan;
                inf_d  = inf_q  | prod_inf;
                zero_d = zero_q | prod_zero;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            nan_q   <= 1'b0;
            inf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            nan_q   <= nan_d;
            inf_q   <= inf_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign vec_out   = res_q;
    assign flag_nan  = nan_q;
    assign flag_inf  = inf_q;
    assign flag_zero = zero_q;

endmodule

// File: tb/tb_fp_vec_mul_seq.sv
// Scoreboard bench for fp_vec_mul_seq: a stand-in multiplier answers the DUT,
// a driver pushes expected result vectors, a monitor compares on every output.
module tb_fp_vec_mul_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] vec_a = '0;
    logic [127:0] vec_b = '0;
    logic [31:0]  mul_a, mul_b, mul_out;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] vec_out;
    logic         flag_nan, flag_inf, flag_zero, busy;

    logic         in_valid1 = 1'b0;
    logic         in_ready1;
    logic [31:0]  vec_a1 = '0;
    logic [31:0]  vec_b1 = '0;
    logic [31:0]  mul_a1, mul_b1, mul_out1;
    logic         out_valid1;
    logic [31:0]  vec_out1;
    logic         flag_nan1, flag_inf1, flag_zero1, busy1;

    int unsigned  cyc = 0;
    int unsigned  n_chk = 0;
    int unsigned  n_pass = 0;
    bit           bp_mode = 1'b0;
    bit           ready_force = 1'b1;
    bit           prev_valid = 1'b0;

    typedef struct {
        logic [127:0] v;
        logic         nan;
        logic         inf;
        logic         zero;
        int unsigned  acc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the external fp_mul: exact FP32 products for the directed
    // operands and for multiplication by 1.0; an arbitrary mix otherwise.
    function automatic logic [31:0] fpmul(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F800000) return b;
        case ({a, b})
            64'h40000000_3F000000: return 32'h3F800000;
            64'hBFC00000_40000000: return 32'hC0400000;
            64'h40400000_00000000: return 32'h00000000;
            64'h7F800000_00000000: return 32'h7FC00000;
            64'h7F800000_40000000: return 32'h7F800000;
            64'h40400000_40400000: return 32'h41100000;
            default: return (a ^ {b[15:0], b[31:16]}) + 32'h9E3779B9;
        endcase
    endfunction

    assign mul_out  = fpmul(mul_a, mul_b);
    assign mul_out1 = fpmul(mul_a1, mul_b1);

    fp_vec_mul_seq #(.E_WIDTH(8), .M_WIDTH(23), .LANES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .vec_a(vec_a), .vec_b(vec_b), .mul_a(mul_a), .mul_b(mul_b),
        .mul_out(mul_out), .out_valid(out_valid), .out_ready(out_ready),
        .vec_out(vec_out), .flag_nan(flag_nan), .flag_inf(flag_inf),
        .flag_zero(flag_zero), .busy(busy)
    );

    fp_vec_mul_seq #(.E_WIDTH(8), .M_WIDTH(23), .LANES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .vec_a(vec_a1), .vec_b(vec_b1), .mul_a(mul_a1), .mul_b(mul_b1),
        .mul_out(mul_out1), .out_valid(out_valid1), .out_ready(1'b1),
        .vec_out(vec_out1), .flag_nan(flag_nan1), .flag_inf(flag_inf1),
        .flag_zero(flag_zero1), .busy(busy1)
    );

    task automatic chk(input string name, input logic ok,
                       input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (ok === 1'b1) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [127:0] pack4(input logic [31:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    // Reference: per-lane product from the multiplier, flags ORed over all lanes.
    function automatic exp_t model(input logic [127:0] a, input logic [127:0] b,
                                   input int unsigned acc);
        exp_t e;
        logic [31:0] p;
        e.v = '0; e.nan = 1'b0; e.inf = 1'b0; e.zero = 1'b0; e.acc = acc;
        for (int k = 0; k < 4; k++) begin
            p = fpmul(a[k*32 +: 32], b[k*32 +: 32]);
            e.v[k*32 +: 32] = p;
            if (p[30:23] == 8'hFF && p[22:0] != 0) e.nan  = 1'b1;
            if (p[30:23] == 8'hFF && p[22:0] == 0) e.inf  = 1'b1;
            if (p[30:23] == 8'h00 && p[22:0] == 0) e.zero = 1'b1;
        end
        return e;
    endfunction

    // Drive out_ready just after each rising edge: random backpressure or fixed.
    always @(posedge clk) begin
        #1;
        out_ready = bp_mode ? 1'($urandom_range(0, 1)) : ready_force;
    end

    // Monitor: compare every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 1'b0, vec_out, '0);
                end else begin
                    if (!prev_valid)
                        chk("latency", (cyc - sb[0].acc) == 4, cyc - sb[0].acc, 4);
                    chk("vec_out", vec_out === sb[0].v, vec_out, sb[0].v);
                    chk("flags", {flag_nan, flag_inf, flag_zero} === {sb[0].nan, sb[0].inf, sb[0].zero},
                        {flag_nan, flag_inf, flag_zero}, {sb[0].nan, sb[0].inf, sb[0].zero});
                    chk("in_ready_done", in_ready === 1'b0, in_ready, 0);
                    chk("mul_quiet_done", (mul_a === 0) && (mul_b === 0), {mul_a, mul_b}, 0);
                    if (out_ready) void'(sb.pop_front());
                end
            end else if (!busy) begin
                chk("mul_quiet_idle", (mul_a === 0) && (mul_b === 0), {mul_a, mul_b}, 0);
            end
        end
        prev_valid = out_valid;
    end

    // Issue one vector; called and returning 2 time units after a rising edge.
    task automatic send(input logic [127:0] a, input logic [127:0] b,
                        input bit push, input bit hold, output int unsigned acc);
        int unsigned n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        chk("in_ready_wait", in_ready, in_ready, 1);
        vec_a = a; vec_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        if (push) sb.push_back(model(a, b, acc));
        if (!hold) in_valid = 1'b0;
        #1;
    endtask

    logic [127:0] t1a, t1b, t2a, t2b, ra, rb;
    int unsigned  acc0, acc1, n;
    logic [31:0]  specials [7];

    initial begin
        t1a = pack4(32'h3F800000, 32'h40000000, 32'hBFC00000, 32'h40400000);
        t1b = pack4(32'h40000000, 32'h3F000000, 32'h40000000, 32'h00000000);
        t2a = pack4(32'h7F800000, 32'h7F800000, 32'h3F800000, 32'h3F800000);
        t2b = pack4(32'h00000000, 32'h40000000, 32'h3F800000, 32'h3F800000);
        specials = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                     32'h7FC00000, 32'h7F800001, 32'h40490FDB};

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, in_ready, 1);
        chk("rst_out_valid", !out_valid, out_valid, 0);
        chk("rst_busy", !busy, busy, 0);
        chk("rst_vec_out", vec_out === '0, vec_out, '0);
        chk("rst_flags", {flag_nan, flag_inf, flag_zero} === 3'b000, {flag_nan, flag_inf, flag_zero}, 0);
        @(posedge clk); #2;

        // Directed vectors with downstream always ready.
        send(t1a, t1b, 1'b1, 1'b0, acc0);
        send(t2a, t2b, 1'b1, 1'b0, acc0);

        // Held backpressure with an in_valid pulse that must be ignored.
        n = 0;
        while (busy && n < 50) begin @(posedge clk); #2; n++; end
        ready_force = 1'b0;
        @(posedge clk); #2;
        send(t1a, t1b, 1'b1, 1'b0, acc0);
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #2; n++; end
        chk("bp_valid_wait", out_valid, out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            vec_a = t2a; vec_b = t2b; in_valid = (i == 1);
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        chk("bp_still_valid", out_valid, out_valid, 1);
        ready_force = 1'b1;
        @(posedge clk); #2;
        chk("bp_first_ready", out_valid && out_ready, {out_valid, out_ready}, 2'b11);
        @(posedge clk); #2;
        chk("bp_done", !out_valid && in_ready, {out_valid, in_ready}, 2'b01);

        // Reset while idx=2 in ISSUE: everything cleared, no result follows.
        send(t2a, t2b, 1'b0, 1'b0, acc0);
        @(posedge clk); @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, in_ready, 1);
        chk("abort_out_valid", !out_valid, out_valid, 0);
        chk("abort_busy", !busy, busy, 0);
        chk("abort_vec_out", vec_out === '0, vec_out, '0);
        chk("abort_flags", {flag_nan, flag_inf, flag_zero} === 3'b000, {flag_nan, flag_inf, flag_zero}, 0);
        repeat (10) @(posedge clk);
        #2;

        // Back-to-back with in_valid held high.
        send(t2a, t2b, 1'b1, 1'b1, acc0);
        send(t1a, t1b, 1'b1, 1'b0, acc1);
        chk("b2b_spacing", (acc1 - acc0) == 6, acc1 - acc0, 6);

        // Randomised vectors under random backpressure.
        bp_mode = 1'b1;
        for (int v = 0; v < 25; v++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    ra[k*32 +: 32] = 32'h3F800000;
                    rb[k*32 +: 32] = specials[$urandom_range(0, 6)];
                end else begin
                    ra[k*32 +: 32] = $urandom;
                    rb[k*32 +: 32] = $urandom;
                end
            end
            send(ra, rb, 1'b1, 1'b0, acc0);
        end
        bp_mode = 1'b0;
        ready_force = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 200) begin @(posedge clk); #2; n++; end
        chk("drain", sb.size() == 0, sb.size(), 0);

        // Single-lane instance: result one cycle after accept.
        vec_a1 = 32'h40400000; vec_b1 = 32'h40400000;
        chk("l1_in_ready", in_ready1, in_ready1, 1);
        in_valid1 = 1'b1;
        @(posedge clk); #2;
        in_valid1 = 1'b0;
        chk("l1_not_yet", !out_valid1 && busy1, {out_valid1, busy1}, 2'b01);
        @(posedge clk); #2;
        chk("l1_valid", out_valid1, out_valid1, 1);
        chk("l1_vec_out", vec_out1 === 32'h41100000, vec_out1, 32'h41100000);
        chk("l1_flags", {flag_nan1, flag_inf1, flag_zero1} === 3'b000, {flag_nan1, flag_inf1, flag_zero1}, 0);
        @(posedge clk); #2;
        chk("l1_idle", !out_valid1 && in_ready1, {out_valid1, in_ready1}, 2'b01);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
